// File: rtl/jts16b_sndlatch_if.sv
// rtl/jts16b_sndlatch_if.sv - main/sound CPU bus bundle for the sound command latch
//
// Purpose: groups the main-CPU side and the sound-CPU (mapper) side signals.
//   slave  modport : the latch itself
//   master modport : whoever drives the CPU strobes (board glue / testbench)
// Signals:
//   main_wr, main_din[7:0]  command write strobe (level) and byte
//   main_rd                 reply read strobe (level)
//   main_dout[7:0]          reply byte
//   main_full               command FIFO full
//   rply_pend               unread reply waiting
//   ovf, ovf_clr            sticky command-drop flag and its clear
//   snd_rd, snd_wr          sound CPU mapper read/write strobes (level)
//   snd_din[7:0]            reply byte from the sound CPU
//   snd_dout[7:0]           FIFO head byte
//   snd_obf                 FIFO not empty (sound Z80 /INT = ~snd_obf)
interface jts16b_sndlatch_if;
    logic       main_wr;
    logic [7:0] main_din;
    logic       main_rd;
    logic [7:0] main_dout;
    logic       main_full;
    logic       rply_pend;
    logic       ovf;
    logic       ovf_clr;
    logic       snd_rd;
    logic       snd_wr;
    logic [7:0] snd_din;
    logic [7:0] snd_dout;
    logic       snd_obf;

    modport slave (
        input  main_wr, main_din, main_rd, ovf_clr, snd_rd, snd_wr, snd_din,
        output main_dout, main_full, rply_pend, ovf, snd_dout, snd_obf
    );

    modport master (
        output main_wr, main_din, main_rd, ovf_clr, snd_rd, snd_wr, snd_din,
        input  main_dout, main_full, rply_pend, ovf, snd_dout, snd_obf
    );
endinterface

// File: rtl/jts16b_sndlatch.sv
// rtl/jts16b_sndlatch.sv - main->sound command FIFO with a one-byte reply register
//
// Purpose: the main CPU pushes command bytes into a DEPTH-entry FIFO that the
//   sound CPU drains through its mapper port; the sound CPU can leave a single
//   reply byte for the main CPU. All strobes are level signals and act once,
//   on one edge each. Every output is registered.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    jts16b_sndlatch_if.slave (see the interface file for signal list)
// Parameters:
//   DEPTH  FIFO entries, power of two 2..16
//   AW     pointer width, log2(DEPTH)
module jts16b_sndlatch #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    jts16b_sndlatch_if.slave         bus
);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_ZERO = '0;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [7:0]    snd_dout_q, snd_dout_d;
    logic [7:0]    main_dout_q, main_dout_d;
    logic          rply_pend_q, rply_pend_d;
    logic          ovf_q, ovf_d;
    logic          snd_obf_q, snd_obf_d;
    logic          main_full_q, main_full_d;

    // Strobe history, one sample per clk
    logic          main_wr_l_q, main_wr_l_d;
    logic          main_rd_l_q, main_rd_l_d;
    logic          snd_rd_l_q, snd_rd_l_d;
    logic          snd_wr_l_q, snd_wr_l_d;

    logic push, pop, rload, rack;
    logic do_push, do_pop;

    always_comb begin
        // Pop acts on the falling edge of snd_rd so the head byte stays put
        // for the whole Z80 read cycle.
        push  = bus.main_wr & ~main_wr_l_q;
        pop   = ~bus.snd_rd & snd_rd_l_q;
        rload = bus.snd_wr  & ~snd_wr_l_q;
        rack  = ~bus.main_rd & main_rd_l_q;

        do_pop  = pop & (cnt_q != CNT_ZERO);
        // A full FIFO still accepts a push when a real pop frees a slot on the same edge.
        do_push = push & ((cnt_q != CNT_FULL) | do_pop);

        main_wr_l_d = bus.main_wr;
        main_rd_l_d = bus.main_rd;
        snd_rd_l_d  = bus.snd_rd;
        snd_wr_l_d  = bus.snd_wr;

        mem_d = mem_q;
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;

        if (do_push) begin
            mem_d[wp_q] = bus.main_din;
            wp_d        = wp_q + PTR_ONE;
        end
        if (do_pop) begin
            rp_d = rp_q + PTR_ONE;
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + CNT_ONE;
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - CNT_ONE;
        end

        // Outputs computed from the post-edge state; snd_dout freezes when empty.
        snd_obf_d   = (cnt_d != CNT_ZERO);
        main_full_d = (cnt_d == CNT_FULL);
        snd_dout_d  = (cnt_d != CNT_ZERO) ? mem_d[rp_d] : snd_dout_q;

        // Overflow set has priority over clear.
        ovf_d = ovf_q;
        if (push && !do_push) begin
            ovf_d = 1'b1;
        end else if (bus.ovf_clr) begin
            ovf_d = 1'b0;
        end

        // Reply load has priority over acknowledge.
        main_dout_d = main_dout_q;
        rply_pend_d = rply_pend_q;
        if (rload) begin
            main_dout_d = bus.snd_din;
            rply_pend_d = 1'b1;
        end else if (rack) begin
            rply_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q       <= '{default: 8'h00};
            wp_q        <= '0;
            rp_q        <= '0;
            cnt_q       <= '0;
            snd_dout_q  <= 8'hFF;
            main_dout_q <= 8'h00;
            rply_pend_q <= 1'b0;
            ovf_q       <= 1'b0;
            snd_obf_q   <= 1'b0;
            main_full_q <= 1'b0;
            main_wr_l_q <= 1'b0;
            main_rd_l_q <= 1'b0;
            snd_rd_l_q  <= 1'b0;
            snd_wr_l_q  <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            cnt_q       <= cnt_d;
            snd_dout_q  <= snd_dout_d;
            main_dout_q <= main_dout_d;
            rply_pend_q <= rply_pend_d;
            ovf_q       <= ovf_d;
            snd_obf_q   <= snd_obf_d;
            main_full_q <= main_full_d;
            main_wr_l_q <= main_wr_l_d;
            main_rd_l_q <= main_rd_l_d;
            snd_rd_l_q  <= snd_rd_l_d;
            snd_wr_l_q  <= snd_wr_l_d;
        end
    end

    assign bus.snd_dout  = snd_dout_q;
    assign bus.snd_obf   = snd_obf_q;
    assign bus.main_full = main_full_q;
    assign bus.main_dout = main_dout_q;
    assign bus.rply_pend = rply_pend_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_jts16b_sndlatch.sv
// tb/tb_jts16b_sndlatch.sv - self-checking bench for jts16b_sndlatch
module tb_jts16b_sndlatch;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    jts16b_sndlatch_if bus();

    jts16b_sndlatch #(.DEPTH(DEPTH), .AW(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Reference model state
    logic [7:0] q[$];
    logic [7:0] m_snd_dout;
    logic [7:0] m_main_dout;
    logic       m_pend;
    logic       m_ovf;
    logic       wr_l, rd_l, swr_l, mrd_l;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        q.delete();
        m_snd_dout  = 8'hFF;
        m_main_dout = 8'h00;
        m_pend = 1'b0;
        m_ovf  = 1'b0;
        wr_l = 1'b0; rd_l = 1'b0; swr_l = 1'b0; mrd_l = 1'b0;
    endtask

    // Behaviour at one clock edge, from the strobe rules and a byte queue.
    task automatic model_edge();
        logic push, pop, rload, rack, popped, rejected;
        if (!rst_n) begin
            model_reset();
            return;
        end
        push  = bus.main_wr && !wr_l;
        pop   = !bus.snd_rd && rd_l;
        rload = bus.snd_wr && !swr_l;
        rack  = !bus.main_rd && mrd_l;
        popped = 1'b0;
        rejected = 1'b0;
        if (pop && q.size() > 0) begin
            void'(q.pop_front());
            popped = 1'b1;
        end
        if (push) begin
            if (q.size() < DEPTH) q.push_back(bus.main_din);
            else rejected = 1'b1;
        end
        if (rejected) m_ovf = 1'b1;
        else if (bus.ovf_clr) m_ovf = 1'b0;
        if (q.size() > 0) m_snd_dout = q[0];
        if (rload) begin
            m_main_dout = bus.snd_din;
            m_pend = 1'b1;
        end else if (rack) begin
            m_pend = 1'b0;
        end
        wr_l = bus.main_wr; rd_l = bus.snd_rd; swr_l = bus.snd_wr; mrd_l = bus.main_rd;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".snd_obf"},   {31'd0, bus.snd_obf},   {31'd0, q.size() != 0});
        check({tag, ".main_full"}, {31'd0, bus.main_full}, {31'd0, q.size() == DEPTH});
        check({tag, ".snd_dout"},  {24'd0, bus.snd_dout},  {24'd0, m_snd_dout});
        check({tag, ".main_dout"}, {24'd0, bus.main_dout}, {24'd0, m_main_dout});
        check({tag, ".rply_pend"}, {31'd0, bus.rply_pend}, {31'd0, m_pend});
        check({tag, ".ovf"},       {31'd0, bus.ovf},       {31'd0, m_ovf});
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic push_byte(input logic [7:0] b);
        bus.main_din = b;
        bus.main_wr = 1'b1;
        cycle("push");
        bus.main_wr = 1'b0;
        cycle("push_idle");
    endtask

    task automatic pop_byte(input logic [7:0] exp);
        check("pop_head", {24'd0, bus.snd_dout}, {24'd0, exp});
        bus.snd_rd = 1'b1;
        cycle("pop");
        bus.snd_rd = 1'b0;
        cycle("pop_idle");
    endtask

    initial begin
        bus.main_wr = 0; bus.main_din = 0; bus.main_rd = 0; bus.ovf_clr = 0;
        bus.snd_rd = 0; bus.snd_wr = 0; bus.snd_din = 0;
        model_reset();
        #12;
        check_all("reset");
        check("reset.snd_dout_ff", {24'd0, bus.snd_dout}, 32'hFF);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: long write strobe -> single push
        bus.main_din = 8'h3A;
        bus.main_wr = 1'b1;
        cycle("t1");
        check("t1.dout", {24'd0, bus.snd_dout}, 32'h3A);
        check("t1.obf", {31'd0, bus.snd_obf}, 32'd1);
        repeat (4) cycle("t1_hold");
        bus.main_wr = 1'b0;
        cycle("t1_rel");

        // 2: long read strobe, pop on the falling edge only
        bus.snd_rd = 1'b1;
        repeat (4) begin
            cycle("t2_hold");
            check("t2.stable", {24'd0, bus.snd_dout}, 32'h3A);
        end
        bus.snd_rd = 1'b0;
        cycle("t2_fall");
        check("t2.obf", {31'd0, bus.snd_obf}, 32'd0);
        check("t2.dout", {24'd0, bus.snd_dout}, 32'h3A);

        // 3: fill, overflow, drain in order, sticky ovf
        for (int i = 1; i <= 4; i++) push_byte(8'(i));
        check("t3.full", {31'd0, bus.main_full}, 32'd1);
        push_byte(8'h05);
        check("t3.ovf", {31'd0, bus.ovf}, 32'd1);
        for (int i = 1; i <= 4; i++) pop_byte(8'(i));
        check("t3.ovf_sticky", {31'd0, bus.ovf}, 32'd1);
        bus.ovf_clr = 1'b1;
        cycle("t3_clr");
        bus.ovf_clr = 1'b0;
        check("t3.ovf_clr", {31'd0, bus.ovf}, 32'd0);

        // 4: full FIFO, push + pop on the same edge, then wrapping pairs
        for (int i = 0; i < 4; i++) push_byte(8'hA0 + 8'(i));
        bus.snd_rd = 1'b1;
        cycle("t4_rd");
        bus.snd_rd = 1'b0;
        bus.main_din = 8'h09;
        bus.main_wr = 1'b1;
        cycle("t4_both");
        bus.main_wr = 1'b0;
        cycle("t4_idle");
        check("t4.no_ovf", {31'd0, bus.ovf}, 32'd0);
        check("t4.full", {31'd0, bus.main_full}, 32'd1);
        check("t4.head", {24'd0, bus.snd_dout}, 32'hA1);
        for (int i = 0; i < 10; i++) begin
            bus.snd_rd = 1'b1;
            cycle("t4_prd");
            bus.snd_rd = 1'b0;
            bus.main_din = 8'($urandom);
            bus.main_wr = 1'b1;
            cycle("t4_pair");
            bus.main_wr = 1'b0;
            cycle("t4_pidle");
        end
        while (q.size() > 0) pop_byte(q[0]);

        // 5: push into empty with a simultaneous (ignored) pop
        bus.snd_rd = 1'b1;
        cycle("t5_rd");
        bus.snd_rd = 1'b0;
        bus.main_din = 8'h55;
        bus.main_wr = 1'b1;
        cycle("t5_both");
        bus.main_wr = 1'b0;
        check("t5.obf", {31'd0, bus.snd_obf}, 32'd1);
        check("t5.dout", {24'd0, bus.snd_dout}, 32'h55);
        cycle("t5_idle");
        pop_byte(8'h55);

        // 6: reply path, load beats ack
        bus.snd_din = 8'hC3;
        bus.snd_wr = 1'b1;
        cycle("t6_ld");
        bus.snd_wr = 1'b0;
        check("t6.mdout", {24'd0, bus.main_dout}, 32'hC3);
        check("t6.pend", {31'd0, bus.rply_pend}, 32'd1);
        bus.main_rd = 1'b1;
        cycle("t6_rd");
        bus.main_rd = 1'b0;
        bus.snd_din = 8'h7E;
        bus.snd_wr = 1'b1;
        cycle("t6_both");
        bus.snd_wr = 1'b0;
        check("t6.pend2", {31'd0, bus.rply_pend}, 32'd1);
        check("t6.mdout2", {24'd0, bus.main_dout}, 32'h7E);
        bus.main_rd = 1'b1;
        cycle("t6_rd2");
        bus.main_rd = 1'b0;
        cycle("t6_ack");
        check("t6.acked", {31'd0, bus.rply_pend}, 32'd0);

        // Random strobe traffic; pop rate varies per phase to reach full and empty
        for (int ph = 0; ph < 4; ph++) begin
            int rd_bias;
            rd_bias = (ph % 2 == 0) ? 7 : 2;
            for (int c = 0; c < 400; c++) begin
                bus.main_din = 8'($urandom);
                bus.snd_din  = 8'($urandom);
                if ($urandom_range(0, 2) == 0) bus.main_wr = ~bus.main_wr;
                if ($urandom_range(0, rd_bias) == 0) bus.snd_rd = ~bus.snd_rd;
                if ($urandom_range(0, 4) == 0) bus.snd_wr = ~bus.snd_wr;
                if ($urandom_range(0, 4) == 0) bus.main_rd = ~bus.main_rd;
                bus.ovf_clr = ($urandom_range(0, 15) == 0);
                cycle("rnd");
            end
        end

        // Mid-stream asynchronous reset
        bus.ovf_clr = 1'b0;
        bus.main_wr = 1'b0; bus.snd_rd = 1'b0; bus.snd_wr = 1'b0; bus.main_rd = 1'b0;
        cycle("pre_rst");
        push_byte(8'h11);
        push_byte(8'h22);
        bus.snd_din = 8'h99;
        bus.snd_wr = 1'b1;
        cycle("pre_rst_ld");
        @(posedge clk);
        model_edge();
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        check("rst.snd_dout", {24'd0, bus.snd_dout}, 32'hFF);
        check("rst.obf", {31'd0, bus.snd_obf}, 32'd0);
        bus.snd_wr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) cycle("post_rst");
        push_byte(8'h44);
        pop_byte(8'h44);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
